// File: rtl/synch_arbiter.sv
// Round-robin arbiter sharing the synch_mem register file among NUM_REQ cores.
// States: IDLE = grant a request | ACCESS = one-cycle memory access | RESP = hold response until accepted.
module synch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*36-1:0]      req_addr,
  input  logic [NUM_REQ*DEPTH-1:0]   req_data,
  input  logic [NUM_REQ*3-1:0]       req_type,
  output logic [35:0]                mem_addr,
  output logic [DEPTH-1:0]           mem_data,
  output logic [3:0]                 mem_id,
  output logic [2:0]                 mem_type,
  output logic [3:0]                 mem_we,
  input  logic [31:0]                mem_rdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [3:0]                 resp_id,
  output logic [2:0]                 resp_type,
  output logic [31:0]                resp_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] T_STORE = 3'b111;
  localparam logic [2:0] T_FADD  = 3'b010;
  localparam logic [2:0] T_READ  = 3'b100;

  state_t               state_q;
  logic [3:0]           rr_ptr_q, rr_ptr_d;
  logic [35:0]          addr_q;
  logic [DEPTH-1:0]     data_q;
  logic [2:0]           type_q;
  logic [3:0]           id_q;
  logic [3:0]           mem_we_q;
  logic                 resp_valid_q;
  logic [3:0]           resp_id_q;
  logic [2:0]           resp_type_q;
  logic [31:0]          resp_data_q;

  logic                 grant_found;
  logic [3:0]           grant_id;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [35:0]          sel_addr;
  logic [DEPTH-1:0]     sel_data;
  logic [2:0]           sel_type;
  logic [3:0]           we_d;
  int                   off;
  int                   best_off;

  // Winner is the valid requester at the smallest rotational distance from rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    sel_addr    = '0;
    sel_data    = '0;
    sel_type    = '0;
    best_off    = NUM_REQ;
    off         = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = j - int'(rr_ptr_q);
      if (off < 0) off = off + NUM_REQ;
      if (req_valid[j] && (off < best_off)) begin
        best_off    = off;
        grant_found = 1'b1;
        grant_id    = 4'(j);
        grant_oh    = '0;
        grant_oh[j] = 1'b1;
        sel_addr    = req_addr[36*j +: 36];
        sel_data    = req_data[DEPTH*j +: DEPTH];
        sel_type    = req_type[3*j +: 3];
      end
    end
  end

  always_comb begin
    rr_ptr_d = (grant_id == 4'(NUM_REQ-1)) ? 4'd0 : grant_id + 4'd1;
    we_d     = '0;
    if ((sel_type == T_STORE) || (sel_type == T_FADD)) we_d[sel_addr[3:2]] = 1'b1;
  end

  function automatic logic [2:0] map_resp(input logic [2:0] t);
    if (t == T_FADD)                        return 3'b101;
    else if ((t == T_STORE) || (t == T_READ)) return 3'b110;
    else                                    return 3'b000;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      type_q       <= '0;
      id_q         <= '0;
      mem_we_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_type_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            addr_q   <= sel_addr;
            data_q   <= sel_data;
            type_q   <= sel_type;
            id_q     <= grant_id;
            rr_ptr_q <= rr_ptr_d;
            mem_we_q <= we_d;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory writes on this same edge, so mem_rdata is still the old value.
          mem_we_q     <= '0;
          resp_data_q  <= mem_rdata;
          resp_id_q    <= id_q;
          resp_type_q  <= map_resp(type_q);
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (rst && (state_q == IDLE)) ? grant_oh : '0;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_id     = id_q;
  assign mem_type   = type_q;
  assign mem_we     = mem_we_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_type  = resp_type_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_synch_arbiter.sv
// Directed bench for synch_arbiter with a small behavioural synch_mem register model.
module tb_synch_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 512;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*36-1:0]    req_addr;
  logic [NUM_REQ*DEPTH-1:0] req_data;
  logic [NUM_REQ*3-1:0]     req_type;
  logic [35:0]              mem_addr;
  logic [DEPTH-1:0]         mem_data;
  logic [3:0]               mem_id;
  logic [2:0]               mem_type;
  logic [3:0]               mem_we;
  logic [31:0]              mem_rdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [3:0]               resp_id;
  logic [2:0]               resp_type;
  logic [31:0]              resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] regs [4] = '{default: 32'd0};

  always #5 clk = ~clk;

  synch_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_id(mem_id),
    .mem_type(mem_type), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_type(resp_type), .resp_data(resp_data)
  );

  assign mem_rdata = regs[mem_addr[3:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) begin
        if (mem_type == 3'b111)      regs[k] <= mem_data[31:0];
        else if (mem_type == 3'b010) regs[k] <= regs[k] + {17'd0, mem_data[46:32]};
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [2:0] t, input logic [35:0] a, input logic [63:0] d);
    req_type[3*idx +: 3]      = t;
    req_addr[36*idx +: 36]    = a;
    req_data[DEPTH*idx +: DEPTH] = {{(DEPTH-64){1'b0}}, d};
  endtask

  task automatic set_all_read4();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'b100, 36'h4, 64'd0);
  endtask

  task automatic txn(input int idx, input logic [2:0] t, input logic [35:0] a, input logic [63:0] d,
                     input logic [3:0] e_we, input logic [2:0] e_rt, input logic [31:0] e_rd);
    @(negedge clk);
    set_req(idx, t, a, d);
    req_valid = 4'(1 << idx);
    #1 chk("grant", req_ready, 64'(1 << idx));
    @(negedge clk);
    req_valid = '0;
    chk("access_we", mem_we, e_we);
    chk("access_id", mem_id, 64'(idx));
    chk("access_addr", mem_addr, a);
    chk("access_type", mem_type, t);
    @(negedge clk);
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, 64'(idx));
    chk("resp_type", resp_type, e_rt);
    chk("resp_data", resp_data, e_rd);
  endtask

  initial begin
    rst        = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '1;
    req_addr   = '0;
    req_data   = '0;
    req_type   = '0;
    set_req(0, 3'b100, 36'h0, 64'd0);
    set_req(1, 3'b100, 36'h0, 64'd0);
    set_req(2, 3'b100, 36'h0, 64'd0);
    set_req(3, 3'b100, 36'h0, 64'd0);

    // Reset held with every requester asserting.
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_resp_data", resp_data, 0);
    end
    rst = 1'b1;
    #1 chk("first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("first_id", mem_id, 0);
    chk("first_we", mem_we, 0);
    @(negedge clk);
    chk("first_resp_valid", resp_valid, 1);
    chk("first_resp_id", resp_id, 0);

    // Store then read back.
    txn(1, 3'b111, 36'h8, 64'hAB, 4'b0100, 3'b110, 32'h0);
    txn(1, 3'b100, 36'h8, 64'h0,  4'b0000, 3'b110, 32'hAB);

    // Fetch-add and same-register serialization.
    txn(3, 3'b111, 36'h0, 64'd5, 4'b0001, 3'b110, 32'd0);
    txn(2, 3'b010, 36'h0, 64'h3_0000_0000, 4'b0001, 3'b101, 32'd5);
    txn(0, 3'b100, 36'h0, 64'd0, 4'b0000, 3'b110, 32'd8);
    txn(1, 3'b010, 36'h0, 64'h2_0000_0000, 4'b0001, 3'b101, 32'd8);
    txn(3, 3'b100, 36'h0, 64'd0, 4'b0000, 3'b110, 32'd10);

    // Round-robin with all four requesting; pointer is at 0 here.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_all_read4();
        req_valid = '1;
      end
      #1 chk("rr_grant", req_ready, 64'(1 << (k % 4)));
      @(negedge clk);
      chk("rr_busy_ready", req_ready, 0);
      chk("rr_mem_id", mem_id, 64'(k % 4));
      @(negedge clk);
      chk("rr_resp_valid", resp_valid, 1);
      chk("rr_resp_id", resp_id, 64'(k % 4));
      if (k == 4) req_valid = '0;
    end

    // Back-pressure: response held while others request.
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(2, 3'b111, 36'hC, 64'h55);
    req_valid = 4'b0100;
    #1 chk("bp_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '1;
    chk("bp_we", mem_we, 4'b1000);
    @(negedge clk);
    chk("bp_resp_valid", resp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_id", resp_id, 2);
      chk("bp_hold_type", resp_type, 3'b110);
      chk("bp_hold_data", resp_data, 0);
      chk("bp_no_grant", req_ready, 0);
      chk("bp_no_we", mem_we, 0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;

    // Unknown type: error response, no write.
    txn(0, 3'b011, 36'hC, 64'h77, 4'b0000, 3'b000, 32'h55);
    txn(0, 3'b100, 36'hC, 64'h0,  4'b0000, 3'b110, 32'h55);

    // Reset during RESP drops the response and rewinds the pointer.
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(1, 3'b111, 36'h4, 64'h99);
    req_valid = 4'b0010;
    #1 chk("rm_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("rm_we", mem_we, 4'b0010);
    @(negedge clk);
    chk("rm_resp_valid_pre", resp_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_resp_dropped", resp_valid, 0);
    chk("rm_resp_data_clr", resp_data, 0);
    chk("rm_mem_addr_clr", mem_addr, 0);
    rst        = 1'b1;
    resp_ready = 1'b1;
    set_all_read4();
    req_valid = '1;
    #1 chk("rm_ptr_zero", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("rm_after_id", mem_id, 0);
    @(negedge clk);
    chk("rm_write_kept", resp_data, 32'h99);
    chk("rm_after_resp_id", resp_id, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synch_arbiter.md
# synch_arbiter

- Shares the single synchronization-register memory (four 32-bit sync registers behind `synch_mem`) among `NUM_REQ` requesting cores.
- Arbitration is round-robin. Each accepted request is driven to the memory for exactly one cycle with a single write strobe.
- The pre-access register value is returned to the winner on a valid/ready response channel, tagged with the requester id.
- Sits between the core-side sync request ports and `synch_mem`. At most one transaction is in flight.

## Interface

- `NUM_REQ`, 4: number of requesters, 1..16; requester index is the 4-bit id.
- `DEPTH`, 512: memory data width, matching `synch_mem`. Only bits [46:0] are meaningful: [31:0] store value, [46:32] fetch-add increment.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_addr`  in  NUM_REQ*36  flattened addresses; slice i = [36*i +: 36].
- `req_data`  in  NUM_REQ*DEPTH  flattened request data.
- `req_type`  in  NUM_REQ*3  flattened packet types: 3'b111 store, 3'b010 fetch-add, 3'b100 read.
- `mem_addr`  out  36  to `synch_mem` addr_req_in.
- `mem_data`  out  DEPTH  to `synch_mem` data_in.
- `mem_id`  out  4  to `synch_mem` id_req_in.
- `mem_type`  out  3  to `synch_mem` packet_type_req_in.
- `mem_we`  out  4  one-hot register write enable, index = `mem_addr[3:2]`.
- `mem_rdata`  in  32  `synch_mem` data_out[31:0], combinational register read.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  4  id of the requester that owns the response.
- `resp_type`  out  3  response packet type.
- `resp_data`  out  32  register value before the access.

## Operation

- FSM states:
  - IDLE: accept a request.
  - ACCESS: one-cycle memory access.
  - RESP: hold the response.
- IDLE:
  - The winner is the first requester with `req_valid` high, searching upward from `rr_ptr` and wrapping at NUM_REQ.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On valid&ready, latch addr/data/type, set id=winner, set `rr_ptr` = winner+1 mod NUM_REQ, and go to ACCESS.
  - With no request pending, stay in IDLE; `rr_ptr` is unchanged.
- ACCESS:
  - `mem_*` are driven from the latch.
  - `mem_we[addr[3:2]]` = 1 only for type 111 or 010.
  - `resp_data` <= `mem_rdata`. The memory writes at the same edge, so the captured value is the old one.
  - Go to RESP.
- RESP:
  - `resp_valid` = 1; `resp_id`/`resp_type`/`resp_data` are held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
- Response type mapping:
  - 010 → 3'b101.
  - 111 or 100 → 3'b110.
  - Any other type → 3'b000 (error), with `mem_we` = 0 and the access still performed.
- Address bits [35:4] are passed through unchecked. Only [3:2] select the register.
- `req_ready` is all-zero outside IDLE.
- `mem_we` is zero outside ACCESS.
- `mem_addr/data/id/type` outside ACCESS hold the last latched value.

## Timing

- Reset (`rst`=0 at a clock edge):
  - State goes to IDLE, `rr_ptr` = 0, latches cleared.
  - All outputs read 0: `req_ready`, `mem_we`, `resp_valid`, `resp_*`, `mem_*`.
  - Reset dominates in every state. An in-flight transaction is dropped with no response and no write, unless the write edge already occurred.
- Latency:
  - Accept in cycle N.
  - `mem_we` in cycle N+1.
  - `resp_valid` from cycle N+2.
- Throughput: one transaction per 3 cycles with `resp_ready` held high; a requester may be re-granted in the IDLE cycle after RESP.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers hold `req_valid` and are granted in rotation. With all NUM_REQ asserting continuously, starvation is bounded at NUM_REQ−1 transactions.
- Back-pressure: `resp_ready` low keeps RESP indefinitely. No new request is accepted and no write is issued meanwhile.
- Same-register ordering: two fetch-adds to one register are serialized. The second's `resp_data` equals the first's result.

## Test plan

- Reset then idle: hold `rst`=0 for 2 cycles with all `req_valid`=1 → `req_ready`=0, `resp_valid`=0 and `mem_we`=0 throughout; first grant after release goes to requester 0.
- Store then read:
  - Req 1 issues type 111, addr 0x8, data 0x0000_00AB → cycle N+1 `mem_we`=4'b0100; `resp_type`=110, `resp_id`=1, `resp_data`=old value 0.
  - Req 1 then issues type 100 to addr 0x8 → `resp_data`=0xAB, `mem_we`=0.
- Fetch-add:
  - Reg 0 holds 5; req 2 issues type 010, data[46:32]=3 → `resp_type`=101, `resp_data`=5.
  - A following read of reg 0 returns 8.
- Round-robin: all 4 requesters hold valid with `resp_ready`=1 → grant order 0,1,2,3,0, each 3 cycles apart; `resp_id` follows the same order.
- Back-pressure and error: hold `resp_ready`=0 for 5 cycles → `resp_*` stable, no grants. Then send type 011 → `resp_type`=000, no `mem_we`.
- Reset mid-operation: assert `rst`=0 during RESP → `resp_valid` drops next edge; the pending response is never delivered and `rr_ptr` returns to 0.
